// File: rtl/spr_pkg.sv
// Shared types and elaboration helpers for the byte-write-enable single-port RAM.
package spr_pkg;

    typedef enum logic [0:0] {
        StInit,
        StIdle
    } spr_state_t;

    function automatic int unsigned nbytes(input int unsigned dw);
        return dw / 8;
    endfunction

    // True when the data width is whole bytes and the array fits the address space.
    function automatic bit cfg_ok(input int unsigned aw, input int unsigned dw,
                                  input int unsigned depth);
        return (dw > 0) && ((dw % 8) == 0) && (depth >= 1) && (64'(depth) <= (64'd1 << aw));
    endfunction

endpackage

// File: rtl/spr_bwe_ram_array.sv
// Storage only: byte-enabled write and a registered synchronous read, no reset.
module spr_array
    import spr_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [nbytes(DW)-1:0]  be_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DW-1:0]          wdata_i,
    output logic [DW-1:0]          rdata_o
);

    localparam int unsigned NB = nbytes(DW);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spr_bwe_ram.sv
// Single-port RAM with byte write enables, read-valid strobe, optional output
// register and a zero-fill sweep engine run after reset or on CLR.
module spr_bwe_ram
    import spr_pkg::*;
#(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 16,
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned RD_PIPE       = 0,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   wen_i,
    input  logic [nbytes(DW)-1:0]  be_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DW-1:0]          wdata_i,
    input  logic                   clr_i,
    output logic                   rdy_o,
    output logic                   rvalid_o,
    output logic [DW-1:0]          rdata_o,
    output logic                   busy_o
);

    localparam int unsigned NB         = nbytes(DW);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW:0] DepthW     = (AW + 1)'(DEPTH);
    localparam spr_state_t ResetState  = (INIT_ON_RESET != 0) ? StInit : StIdle;

    if (!cfg_ok(AW, DW, DEPTH)) begin : g_cfg_err
        $error("spr_bwe_ram: DW must be a multiple of 8 and DEPTH <= 2**AW");
    end

    spr_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic sweep, in_range, acc_wr, acc_rd;

    assign sweep    = (state_q == StInit);
    assign in_range = ({1'b0, addr_i} < DepthW);
    assign rdy_o    = (state_q == StIdle) & ~clr_i;
    assign acc_wr   = req_i & rdy_o & wen_i;
    assign acc_rd   = req_i & rdy_o & ~wen_i;
    assign busy_o   = sweep;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr_i) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the write port while busy; user accesses cannot be accepted then.
    logic          arr_we;
    logic [NB-1:0] arr_be;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata, arr_rdata;

    assign arr_we    = sweep | (acc_wr & in_range);
    assign arr_be    = sweep ? {NB{1'b1}} : be_i;
    assign arr_addr  = sweep ? cnt_q : addr_i;
    assign arr_wdata = sweep ? '0 : wdata_i;

    spr_array #(
        .AW   (AW),
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .re_i   (acc_rd),
        .be_i   (arr_be),
        .addr_i (arr_addr),
        .wdata_i(arr_wdata),
        .rdata_o(arr_rdata)
    );

    // zero1_q forces the first read stage to zero after reset and for out-of-range reads.
    logic          rd_v1_q, zero1_q;
    logic [DW-1:0] data1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_v1_q <= 1'b0;
            zero1_q <= 1'b1;
        end else begin
            rd_v1_q <= acc_rd;
            if (acc_rd) begin
                zero1_q <= ~in_range;
            end
        end
    end

    assign data1 = zero1_q ? '0 : arr_rdata;

    if (RD_PIPE == 0) begin : g_pipe0
        assign rvalid_o = rd_v1_q;
        assign rdata_o  = data1;
    end else begin : g_pipe1
        logic          rvalid_q;
        logic [DW-1:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rd_v1_q;
                if (rd_v1_q) begin
                    rdata_q <= data1;
                end
            end
        end

        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end

endmodule

// File: tb/tb_spr_bwe_ram.sv
// Scoreboard bench: two RAM instances (DEPTH 256 / 1-cycle reads, DEPTH 200 / 2-cycle reads)
// share one stimulus stream; each has its own expected-read queue and monitor.
module tb_spr_bwe_ram;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [15:0] wdata = 16'h0000;

    logic        rdy_a, rvalid_a, busy_a;
    logic        rdy_b, rvalid_b, busy_b;
    logic [15:0] rdata_a, rdata_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spr_bwe_ram #(
        .AW(8), .DW(16), .DEPTH(256), .RD_PIPE(0), .INIT_ON_RESET(1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .clr_i(clr), .rdy_o(rdy_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .busy_o(busy_a)
    );

    spr_bwe_ram #(
        .AW(8), .DW(16), .DEPTH(200), .RD_PIPE(1), .INIT_ON_RESET(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .clr_i(clr), .rdy_o(rdy_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .busy_o(busy_b)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors: pop on every RVALID, compare data and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rvalid_a) begin
                if (qa.size() == 0) begin
                    check("unexpected_rvalid_a", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    check("rdata_a", 32'(rdata_a), 32'(e.data));
                    check("latency_a", 32'(cyc), 32'(e.due));
                end
            end else if (qa.size() > 0 && qa[0].due < cyc) begin
                e = qa.pop_front();
                check("missing_rvalid_a", 32'(cyc), 32'(e.due));
            end
            if (rvalid_b) begin
                if (qb.size() == 0) begin
                    check("unexpected_rvalid_b", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    check("rdata_b", 32'(rdata_b), 32'(e.data));
                    check("latency_b", 32'(cyc), 32'(e.due));
                end
            end else if (qb.size() > 0 && qb[0].due < cyc) begin
                e = qb.pop_front();
                check("missing_rvalid_b", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One access cycle, started in the low phase; returns at the following negedge.
    task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                          input logic [1:0] b, input logic c, input logic exp_rdy,
                          input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        req = 1'b1; wen = w; addr = a; wdata = d; be = b; clr = c;
        #1;
        check("rdy_a", 32'(rdy_a), 32'(exp_rdy));
        check("rdy_b", 32'(rdy_b), 32'(exp_rdy));
        if (exp_rdy && !w) begin
            e.data = ea; e.due = cyc + 1; qa.push_back(e);
            e.data = eb; e.due = cyc + 2; qb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0; wen = 1'b0; be = 2'b00; clr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        access(1'b1, a, d, b, 1'b0, 1'b1, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] ea, input logic [15:0] eb);
        access(1'b0, a, 16'h0, 2'b00, 1'b0, 1'b1, ea, eb);
    endtask

    // Called just after the first busy cycle begins; counts busy cycles of each instance.
    task automatic measure_sweep(input string tag);
        int na = 0;
        int nb = 0;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) begin na++; if (rdy_a) bad++; end
            if (busy_b) begin nb++; if (rdy_b) bad++; end
            @(negedge clk);
            #1;
        end
        check({tag, "_len_a"}, 32'(na), 32'd256);
        check({tag, "_len_b"}, 32'(nb), 32'd200);
        check({tag, "_rdy_low"}, 32'(bad), 32'd0);
        check({tag, "_rdy_after_a"}, 32'(rdy_a), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid_a"}, 32'(rvalid_a), 32'd0);
        check({tag, "_rvalid_b"}, 32'(rvalid_b), 32'd0);
        check({tag, "_rdata_a"}, 32'(rdata_a), 32'd0);
        check({tag, "_rdata_b"}, 32'(rdata_b), 32'd0);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd1);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_rdy_a", 32'(rdy_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        measure_sweep("init");

        rd(8'h7F, 16'h0000, 16'h0000);

        // Byte-enable merging.
        wr(8'h10, 16'hBEEF, 2'b11);
        wr(8'h10, 16'h12AA, 2'b10);
        rd(8'h10, 16'h12EF, 16'h12EF);
        wr(8'h10, 16'h7777, 2'b00);
        rd(8'h10, 16'h12EF, 16'h12EF);

        // Back-to-back reads keep order and one-per-cycle throughput.
        wr(8'h01, 16'h0101, 2'b11);
        wr(8'h02, 16'h0202, 2'b11);
        wr(8'h03, 16'h0303, 2'b11);
        rd(8'h01, 16'h0101, 16'h0101);
        rd(8'h02, 16'h0202, 16'h0202);
        rd(8'h03, 16'h0303, 16'h0303);

        // CLR beats a simultaneous write; the read accepted just before sees old data.
        wr(8'h20, 16'h3333, 2'b11);
        rd(8'h20, 16'h3333, 16'h3333);
        access(1'b1, 8'h20, 16'h5555, 2'b11, 1'b1, 1'b0, 16'h0, 16'h0);
        #1;
        measure_sweep("clr");
        rd(8'h20, 16'h0000, 16'h0000);
        rd(8'h10, 16'h0000, 16'h0000);

        // Range check differs between the two depths.
        wr(8'hF0, 16'hABCD, 2'b11);
        rd(8'hF0, 16'hABCD, 16'h0000);
        wr(8'h00, 16'h1111, 2'b11);
        wr(8'hC7, 16'h2222, 2'b11);
        rd(8'h00, 16'h1111, 16'h1111);
        rd(8'hC7, 16'h2222, 16'h2222);

        // Reset while reads are in flight.
        wr(8'h10, 16'h4242, 2'b11);
        req = 1'b1; wen = 1'b0; addr = 8'h10;
        #1;
        check("midread_rdy", 32'(rdy_a & rdy_b), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_reset_outputs("midread");
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        measure_sweep("rst1");
        rd(8'h10, 16'h0000, 16'h0000);

        // Reset partway through a sweep restarts it from zero.
        wr(8'h10, 16'h4242, 2'b11);
        rd(8'h10, 16'h4242, 16'h4242);
        access(1'b1, 8'h00, 16'h0, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0);
        repeat (100) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsweep");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        measure_sweep("rst2");
        rd(8'h10, 16'h0000, 16'h0000);
        rd(8'hC7, 16'h0000, 16'h0000);

        repeat (4) @(negedge clk);
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spr_bwe_ram.md
# spr_bwe_ram

Parametrised single-port RAM with per-byte write enables, a request/ready handshake and a read-valid strobe. Adds a configurable read pipeline and a hardware clear engine that zero-fills the array after reset or on command. It is the general-purpose on-chip buffer for datapath blocks that need masked writes and a known memory state without a software init pass.

## Interface
- AW, 8: address width
- DW, 16: data width; multiple of 8
- DEPTH, 256: number of words; 1 ≤ DEPTH ≤ 2**AW
- RD_PIPE, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency
- INIT_ON_RESET, 1: 1 starts a zero-fill sweep on reset release; 0 makes the block ready immediately (contents undefined)

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset; asynchronous and active-low
- REQ  in  1  access request
- WEN  in  1  1 = write, 0 = read; qualified by REQ
- BE  in  DW/8  byte write enables; bit i covers WDATA[8i+7:8i]; ignored on reads
- ADDR  in  AW  word address
- WDATA  in  DW  write data
- CLR  in  1  single-cycle pulse that starts a zero-fill sweep
- RDY  out  1  access accepted this cycle when REQ & RDY
- RVALID  out  1  one-cycle strobe marking RDATA valid
- RDATA  out  DW  read data; holds its last value while RVALID = 0
- BUSY  out  1  clear sweep in progress

## Operation
- FSM states are INIT (sweeping) and IDLE.
- Reset values:
  - state is INIT if INIT_ON_RESET, else IDLE
  - sweep counter = 0
  - RVALID = 0, RDATA = 0
  - BUSY = INIT_ON_RESET
  - internal pipeline valid bits = 0
- INIT:
  - writes all-zero to word `cnt` each cycle, then increments `cnt`.
  - After writing DEPTH-1, goes to IDLE on the next edge. A sweep takes exactly DEPTH cycles.
  - BUSY = 1 and RDY = 0 throughout.
- IDLE:
  - RDY = ~CLR, combinational from state and CLR.
  - CLR in IDLE moves to INIT with `cnt` = 0. CLR has priority over REQ in the same cycle, so that request is not accepted.
  - CLR during INIT restarts the sweep at 0.
- Write (REQ & RDY & WEN): only bytes with BE[i] = 1 are updated. With BE = 0 the access is accepted but has no effect. No RVALID is produced.
- Read (REQ & RDY & ~WEN): the array is read synchronously at the accept edge. RVALID and RDATA follow per Timing.
- Out-of-range address (ADDR ≥ DEPTH): a write is dropped; a read returns RDATA = 0 with a normal RVALID.
- Reads already accepted when CLR arrives complete normally with the pre-clear data.
- Back-to-back reads are supported at one per cycle, and RVALID order equals accept order. There is no back-pressure on RDATA.
- RSTN asserted mid-sweep or mid-read aborts everything:
  - in-flight RVALIDs are lost
  - array contents are not reset, but are re-zeroed when INIT_ON_RESET = 1

## Timing
- Read accepted at edge N gives RVALID = 1 with RDATA = mem[ADDR] for the cycle after edge N+RD_PIPE. Latency is 1 cycle (RD_PIPE = 0) or 2 cycles (RD_PIPE = 1).
- Write accepted at edge N is visible to a read accepted at edge N+1.
- Sweep: with BUSY first asserted in cycle k (after reset release or CLR), RDY rises in cycle k+DEPTH.
- RVALID, RDATA and BUSY are registered outputs. RDY is combinational.

## Structure
- Package `spr_pkg`:
  - state typedef `spr_state_t` {INIT, IDLE}
  - localparam function `nbytes(DW)` = DW/8
  - elaboration check that DW % 8 == 0 and DEPTH ≤ 2**AW
- Sub-module `spr_array`: storage only. Byte-enable write, synchronous read into an internal register, no reset. Instantiated once.
- Top level holds the FSM, sweep counter, write-port mux between the sweep and user writes, range check, and the RD_PIPE stage with its valid bits.

## Test plan
- Reset with INIT_ON_RESET=1, DEPTH=256: BUSY high for exactly 256 cycles, RDY low throughout; then a read of 0x7F gives RDATA = 0x0000 with RVALID one cycle later.
- Write 0xBEEF to 0x10 with BE=2'b11, then write 0x12xx with BE=2'b10: a read of 0x10 returns 0x12EF. A write with BE=2'b00 leaves it unchanged.
- Back-to-back reads of 0x01, 0x02, 0x03 with RD_PIPE=1, after writing 0x0101/0x0202/0x0303: three consecutive RVALIDs starting 2 cycles after the first accept, in order.
- CLR asserted together with REQ (write 0x5555 to 0x20): RDY=0 that cycle, the write is lost, and after the sweep a read of 0x20 returns 0x0000. A read accepted one cycle before CLR returns the old data.
- DEPTH=200, AW=8: a write to 0xF0 is dropped and a read of 0xF0 returns 0x0000 with RVALID; addresses 0x00 and 0xC7 operate normally.
- RSTN pulsed low mid-sweep (cnt≈100) and mid-read: RVALID=0, RDATA=0, BUSY=1 immediately; a full 256-cycle sweep restarts from 0 after release.
